// File: rtl/shim_sts_pkg.sv
// Shared definitions for the SPI status synchronizer shim: snapshot FSM
// encoding, snap_word field layout and the per-group channel count.
package shim_sts_pkg;

    localparam int unsigned NUM_CH       = 8;
    localparam int unsigned SNAP_RUN_BIT = 0;
    localparam int unsigned SNAP_OVR_LSB = 8;
    localparam int unsigned SNAP_DAC_LSB = 16;
    localparam int unsigned SNAP_ADC_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } snap_state_e;

    // Assemble the 32-bit snapshot; bits 7:1 are reserved zero.
    function automatic logic [31:0] pack_snap_word(
        input logic              run,
        input logic [NUM_CH-1:0] ovr,
        input logic [NUM_CH-1:0] dac,
        input logic [NUM_CH-1:0] adc
    );
        logic [31:0] w;
        w                        = 32'd0;
        w[SNAP_RUN_BIT]          = run;
        w[SNAP_OVR_LSB +: NUM_CH] = ovr;
        w[SNAP_DAC_LSB +: NUM_CH] = dac;
        w[SNAP_ADC_LSB +: NUM_CH] = adc;
        return w;
    endfunction

endpackage

// File: rtl/shim_spi_sts_sync_cdc.sv
// Multi-flop synchronizer with a stability qualifier: stable rises once the
// synchronized value has been held for STABLE_COUNT consecutive cycles.
module shim_spi_sts_sync_cdc
    import shim_sts_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int WIDTH        = 1,
    parameter int STABLE_COUNT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             stable
);

    localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_COUNT - 1);

    logic [DEPTH-1:0][WIDTH-1:0] stage_r;
    logic [DEPTH-1:0][WIDTH-1:0] stage_nx_s;
    logic [CW-1:0]               cnt_r;
    logic [CW-1:0]               cnt_nx_s;
    logic                        same_s;

    // Next chain contents and the count of edges the output has held its value
    always_comb begin
        stage_nx_s[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_nx_s[i] = stage_r[i-1];
        end
        same_s = (stage_nx_s[DEPTH-1] == stage_r[DEPTH-1]);
        if (!same_s) begin
            cnt_nx_s = {CW{1'b0}};
        end else if (cnt_r == CNT_SAT) begin
            cnt_nx_s = cnt_r;
        end else begin
            cnt_nx_s = cnt_r + CW'(1'b1);
        end
    end

    // Synchronizer chain and hold counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_r <= {(DEPTH*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            stage_r <= stage_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    assign dout   = stage_r[DEPTH-1];
    assign stable = (cnt_r == CNT_SAT);

endmodule

// File: rtl/shim_spi_sts_sync.sv
// SPI-to-AXI status shim: synchronizes SPI status flags, keeps sticky copies,
// raises a fault summary and produces coherent 32-bit snapshots on request.
module shim_spi_sts_sync
    import shim_sts_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2,
    parameter int SNAP_TIMEOUT = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              spi_running,
    input  logic [NUM_CH-1:0] over_thresh,
    input  logic [NUM_CH-1:0] dac_buf_err,
    input  logic [NUM_CH-1:0] adc_buf_err,
    input  logic              sts_clear,
    input  logic              snap_req,
    output logic              spi_running_stable,
    output logic [NUM_CH-1:0] over_thresh_sticky,
    output logic [NUM_CH-1:0] dac_buf_err_sticky,
    output logic [NUM_CH-1:0] adc_buf_err_sticky,
    output logic              fault,
    output logic              fault_pulse,
    output logic [31:0]       snap_word,
    output logic              snap_valid,
    output logic              snap_timeout,
    output logic              snap_busy
);

    localparam int WCW = $clog2(SNAP_TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SNAP_TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_MAX  = {WCW{1'b1}};

    logic              run_sync_s, run_stb_s;
    logic [NUM_CH-1:0] ovr_sync_s, dac_sync_s, adc_sync_s;
    logic              ovr_stb_s, dac_stb_s, adc_stb_s;
    logic              all_stable_s;

    logic              acc_run_r;
    logic [NUM_CH-1:0] ovr_acc_r, dac_acc_r, adc_acc_r;
    logic [NUM_CH-1:0] ovr_sticky_r, dac_sticky_r, adc_sticky_r;
    logic              fault_s, fault_d_r, fault_pulse_r;

    snap_state_e       state_r, state_nx_s;
    logic [WCW-1:0]    wcnt_r, wcnt_nx_s;
    logic              timeout_r, timeout_nx_s;
    logic              capture_s;
    logic [31:0]       snap_word_r;
    logic              snap_valid_r, snap_timeout_r, snap_busy_r;

    shim_spi_sts_sync_cdc #(.DEPTH(DEPTH), .WIDTH(1), .STABLE_COUNT(STABLE_COUNT)) u_run_sync (
        .clk(aclk), .resetn(aresetn), .din(spi_running), .dout(run_sync_s), .stable(run_stb_s)
    );
    shim_spi_sts_sync_cdc #(.DEPTH(DEPTH), .WIDTH(NUM_CH), .STABLE_COUNT(STABLE_COUNT)) u_ovr_sync (
        .clk(aclk), .resetn(aresetn), .din(over_thresh), .dout(ovr_sync_s), .stable(ovr_stb_s)
    );
    shim_spi_sts_sync_cdc #(.DEPTH(DEPTH), .WIDTH(NUM_CH), .STABLE_COUNT(STABLE_COUNT)) u_dac_sync (
        .clk(aclk), .resetn(aresetn), .din(dac_buf_err), .dout(dac_sync_s), .stable(dac_stb_s)
    );
    shim_spi_sts_sync_cdc #(.DEPTH(DEPTH), .WIDTH(NUM_CH), .STABLE_COUNT(STABLE_COUNT)) u_adc_sync (
        .clk(aclk), .resetn(aresetn), .din(adc_buf_err), .dout(adc_sync_s), .stable(adc_stb_s)
    );

    assign all_stable_s = run_stb_s & ovr_stb_s & dac_stb_s & adc_stb_s;
    assign fault_s      = (|ovr_sticky_r) | (|dac_sticky_r) | (|adc_sticky_r);

    // Accepted values, sticky flags (set beats clear) and fault edge detect
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_run_r     <= 1'b0;
            ovr_acc_r     <= {NUM_CH{1'b0}};
            dac_acc_r     <= {NUM_CH{1'b0}};
            adc_acc_r     <= {NUM_CH{1'b0}};
            ovr_sticky_r  <= {NUM_CH{1'b0}};
            dac_sticky_r  <= {NUM_CH{1'b0}};
            adc_sticky_r  <= {NUM_CH{1'b0}};
            fault_d_r     <= 1'b0;
            fault_pulse_r <= 1'b0;
        end else begin
            if (run_stb_s) acc_run_r <= run_sync_s;
            if (ovr_stb_s) ovr_acc_r <= ovr_sync_s;
            if (dac_stb_s) dac_acc_r <= dac_sync_s;
            if (adc_stb_s) adc_acc_r <= adc_sync_s;
            ovr_sticky_r  <= ovr_acc_r | (ovr_sticky_r & ~{NUM_CH{sts_clear}});
            dac_sticky_r  <= dac_acc_r | (dac_sticky_r & ~{NUM_CH{sts_clear}});
            adc_sticky_r  <= adc_acc_r | (adc_sticky_r & ~{NUM_CH{sts_clear}});
            fault_d_r     <= fault_s;
            fault_pulse_r <= fault_s & ~fault_d_r;
        end
    end

    // Snapshot FSM next state: leave WAIT on full stability or on timeout
    always_comb begin
        state_nx_s   = state_r;
        wcnt_nx_s    = wcnt_r;
        timeout_nx_s = timeout_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (snap_req) begin
                    state_nx_s   = ST_WAIT;
                    wcnt_nx_s    = {WCW{1'b0}};
                    timeout_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (all_stable_s) begin
                    state_nx_s   = ST_CAPTURE;
                    timeout_nx_s = 1'b0;
                end else if (wcnt_r == WAIT_LAST) begin
                    state_nx_s   = ST_CAPTURE;
                    timeout_nx_s = 1'b1;
                end else if (wcnt_r == WAIT_MAX) begin
                    wcnt_nx_s = wcnt_r;
                end else begin
                    wcnt_nx_s = wcnt_r + WCW'(1'b1);
                end
            end
            ST_CAPTURE: begin
                capture_s  = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Snapshot FSM state and registered snapshot outputs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r        <= ST_IDLE;
            wcnt_r         <= {WCW{1'b0}};
            timeout_r      <= 1'b0;
            snap_word_r    <= 32'd0;
            snap_valid_r   <= 1'b0;
            snap_timeout_r <= 1'b0;
            snap_busy_r    <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            wcnt_r         <= wcnt_nx_s;
            timeout_r      <= timeout_nx_s;
            snap_valid_r   <= capture_s;
            snap_timeout_r <= capture_s & timeout_r;
            snap_busy_r    <= (state_nx_s != ST_IDLE);
            if (capture_s) begin
                snap_word_r <= pack_snap_word(acc_run_r, ovr_sticky_r, dac_sticky_r, adc_sticky_r);
            end
        end
    end

    assign spi_running_stable = acc_run_r;
    assign over_thresh_sticky = ovr_sticky_r;
    assign dac_buf_err_sticky = dac_sticky_r;
    assign adc_buf_err_sticky = adc_sticky_r;
    assign fault              = fault_s;
    assign fault_pulse        = fault_pulse_r;
    assign snap_word          = snap_word_r;
    assign snap_valid         = snap_valid_r;
    assign snap_timeout       = snap_timeout_r;
    assign snap_busy          = snap_busy_r;

endmodule
